ifu_align: RTL and testbench
============================

# ifu_align

Instruction aligner and fetch buffer at the consumer end of the fetch path. The program counter issues word fetches; this block accepts the returned 32-bit words, buffers them, and splits them into 16-bit compressed or 32-bit instructions, including 32-bit instructions that straddle a word boundary. It presents one instruction per cycle with its PC and compressed flag to decode. On a redirect it discards stale in-flight words.

## Interface

Parameters:
- XLEN, 32, address width
- DEPTH, 4, word buffer entries (power of two, ≥2)
- RESET_VECTOR, 0, first expected fetch address after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_valid  in  1  returned word valid
- fetch_ready  out  1  buffer can accept a word
- fetch_addr  in  XLEN  word-aligned address of the returned word
- fetch_data  in  32  returned word
- flush  in  1  redirect; discard buffer contents
- flush_addr  in  XLEN  redirect target, halfword-aligned (bit 0 = 0)
- instr_valid  out  1  instruction available
- instr_ready  in  1  decode accepts the instruction
- instr  out  32  instruction; compressed ones are zero-extended in [15:0]
- instr_pc  out  XLEN  address of the instruction
- compressed  out  1  instruction is 16-bit

## Operation

- Reset values: buffer empty, offset 0, expected = RESET_VECTOR; fetch_ready=1, instr_valid=0. instr, instr_pc and compressed are 0 whenever instr_valid=0.
- Word accept happens when fetch_valid && fetch_ready.
  - If fetch_addr == expected: push {addr, data} and increment expected by 4, modulo 2^XLEN.
  - Otherwise the word is dropped as stale. It is still consumed.
- fetch_ready = (count < DEPTH). It does not depend on instr_ready.
- Head word w0 with address a0; next word w1. offset selects a halfword within w0. Let h = offset ? w0[31:16] : w0[15:0].
  - h[1:0] != 2'b11: compressed=1, instr={16'b0,h}, valid when count≥1.
  - h[1:0] == 2'b11, offset 0: instr=w0, valid when count≥1.
  - h[1:0] == 2'b11, offset 1: instr={w1[15:0], w0[31:16]}, valid only when count≥2.
  - instr_pc = a0 + 2·offset.
- Consume happens when instr_valid && instr_ready:
  - compressed, offset 0: set offset to 1, no pop.
  - compressed, offset 1: pop w0, set offset to 0.
  - 32-bit, offset 0: pop w0, offset stays 0.
  - 32-bit, offset 1: pop w0, offset stays 1.
- Outputs stay stable while instr_valid && !instr_ready.
- Flush:
  - Buffer is emptied. offset = flush_addr[1]. expected = flush_addr with bits [1:0] cleared.
  - A word presented in the same cycle as flush is compared against the new expected value. A match is pushed, so a redirect costs no bubble.
  - If flush and a consume happen in the same cycle, flush wins and the consume has no effect.
- Push and pop in the same cycle are both performed. count is unchanged.

## Timing

- The buffer is registered with no bypass. A word accepted in cycle N can produce instr_valid in cycle N+1 at the earliest.
- Throughput is one instruction per cycle while words are available. Two compressed instructions come out of one word in two consecutive cycles.
- A straddling 32-bit instruction waits until the second word has been pushed.
- After a flush in cycle N, instr_valid=0 in cycle N+1 unless a matching word was pushed in cycle N.
- rst_n low mid-operation immediately clears the buffer and outputs to their reset values.

## Configuration

- IFU_ALIGN_RVC_EN defined: compressed support exactly as above.
- IFU_ALIGN_RVC_EN undefined:
  - Every instruction is 32-bit and compressed is tied to 0.
  - offset is fixed at 0 and flush_addr[1] is ignored.
  - Each consume pops one word.
  - The straddle path and the w1 read are removed.

## Structure

- Shared package ifu_pkg holds:
  - ILEN=32 constant
  - is_compressed(halfword) function
  - halfword select helper
  - word-entry struct {addr, data}
- Sub-module ifu_word_fifo is a DEPTH-entry synchronous FIFO.
  - Ports: push, pop, clear, count.
  - Exposes head and head+1 entries for reads.
  - Uses the same clk/rst_n.

## Test plan

- Single 32-bit instruction: RESET_VECTOR=0, word 0x00A00093 @0x0 → instr=0x00A00093, pc=0x0, compressed=0, one cycle after accept.
- Two compressed instructions: word 0x45054501 @0x0 → 0x00004501 at pc 0x0, then 0x00004505 at pc 0x2. The pop happens after the second consume.
- Straddle: word 0x00934501 @0x0, then word 0x123400A0 @0x4 delayed 3 cycles.
  - 0x4501 at pc 0x0, compressed.
  - instr_valid stays 0 until the second word arrives.
  - Then 0x00A00093 at pc 0x2, followed by 0x1234 at pc 0x6, compressed.
- Stale drop: flush to 0x102 while word @0x8 is in flight.
  - @0x8 is dropped.
  - Word 0x4501ABCD @0x100 → instr 0x00004501, pc 0x102.
- Backpressure: instr_ready=0, push 4 words → fetch_ready=0 after the 4th. Outputs stay constant; a 5th fetch_valid is not accepted.
- Simultaneous flush and handshake plus a matching word @flush_addr: consume is ignored, the word is pushed, and the new instruction is valid in the next cycle.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// ILEN fixes the instruction width. ADDR_W sizes the buffered word address.
// A fetch-buffer entry is a word_entry_t holding {addr, data}.
package ifu_pkg;

    localparam int unsigned ILEN   = 32;
    localparam int unsigned ADDR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ILEN-1:0]   data;
    } word_entry_t;

    // RVC encodings use every opcode quadrant except 2'b11.
    function automatic logic is_compressed(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    function automatic logic [15:0] hw_sel(input logic [ILEN-1:0] w, input logic upper);
        return upper ? w[31:16] : w[15:0];
    endfunction

endpackage

// File: rtl/ifu_word_fifo.sv
// DEPTH-entry synchronous word FIFO that exposes the head and head+1 entries.
// Latency: a push is visible at head on the next cycle, with no bypass.
// Backpressure: the caller must not push when count == DEPTH or pop when empty.
// Ports:
//   clk, rst_n           clock and async active-low reset
//   push, push_dat       write one entry at the tail
//   pop                  drop the head entry
//   clear                empty the FIFO
//   head, next, count    read view of the FIFO
// clear wins over pop. A push issued together with clear still lands as the
// only entry.
module ifu_word_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  word_entry_t push_dat,
    input  logic        pop,
    input  logic        clear,
    output word_entry_t head,
    output word_entry_t next,
    output logic [AW:0] count
);

    word_entry_t    mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // The storage array has no reset. Entries are only read below count.
    always_ff @(posedge clk) begin
        if (push) mem[clear ? '0 : wr_ptr] <= push_dat;
    end

    assign head = mem[rd_ptr];
    assign next = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/ifu_align.sv
// Instruction aligner and fetch buffer that splits fetched words into 16/32-bit instructions.
// Latency: a word accepted in cycle N can produce instr_valid in cycle N+1 at the earliest.
// Backpressure: fetch_ready = buffer not full, independent of instr_ready. Outputs hold while stalled.
// Ports:
//   fetch_valid/fetch_ready/fetch_addr/fetch_data   returned fetch words
//   flush/flush_addr                                redirect that discards buffered words
//   instr_valid/instr_ready/instr/instr_pc/compressed   instruction to decode
// Define IFU_ALIGN_RVC_EN to enable compressed (16-bit) instructions.
// Without it, every instruction is a 32-bit word.
module ifu_align
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN         = ADDR_W,
    parameter int unsigned     DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [XLEN-1:0] fetch_addr,
    input  logic [31:0]     fetch_data,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_addr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            compressed
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] expected;
    logic [XLEN-1:0] flush_base;
    logic [XLEN-1:0] match_addr;
    logic            accept;
    logic            push;
    logic            pop;
    logic            consume;
    logic [CW-1:0]   count;
    word_entry_t     w0;
    word_entry_t     w1;
    word_entry_t     push_dat;
    logic            raw_valid;
    logic            raw_cmp;
    logic [ILEN-1:0] raw_instr;
    logic [XLEN-1:0] raw_pc;
    logic            unused_ok;

    // During a redirect, the incoming word is matched against the new target.
    // A returned word that hits the target is kept, so a redirect costs no bubble.
    assign flush_base  = {flush_addr[XLEN-1:2], 2'b00};
    assign match_addr  = flush ? flush_base : expected;
    assign fetch_ready = (count < CW'(DEPTH));
    assign accept      = fetch_valid && fetch_ready;
    assign push        = accept && (fetch_addr == match_addr);
    assign push_dat    = '{addr: fetch_addr, data: fetch_data};
    assign consume     = instr_valid && instr_ready && !flush;

    // On a push, fetch_addr already equals match_addr, so advance from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= RESET_VECTOR;
        end else if (push) begin
            expected <= fetch_addr + XLEN'(4);
        end else begin
            expected <= match_addr;
        end
    end

    ifu_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .clear    (flush),
        .head     (w0),
        .next     (w1),
        .count    (count)
    );

`ifdef IFU_ALIGN_RVC_EN
    // offset selects the halfword of the head word at which the next instruction starts.
    logic        offset;
    logic [15:0] hw;

    assign hw = hw_sel(w0.data, offset);

    always_comb begin
        raw_cmp   = is_compressed(hw);
        raw_instr = '0;
        raw_valid = 1'b0;
        if (raw_cmp) begin
            raw_instr = {16'h0000, hw};
            raw_valid = (count != '0);
        end else if (!offset) begin
            raw_instr = w0.data;
            raw_valid = (count != '0);
        end else begin
            // A 32-bit instruction straddles words: its upper half is w1's low halfword.
            raw_instr = {w1.data[15:0], w0.data[31:16]};
            raw_valid = (count >= CW'(2));
        end
    end

    assign raw_pc = w0.addr + {{(XLEN-2){1'b0}}, offset, 1'b0};

    // A word is retired once its last halfword has been used. A 32-bit
    // instruction at offset 1 ends mid-word, so offset stays 1.
    assign pop = consume && (!raw_cmp || offset);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset <= 1'b0;
        end else if (flush) begin
            offset <= flush_addr[1];
        end else if (consume && raw_cmp) begin
            offset <= !offset;
        end
    end

    assign unused_ok = &{1'b0, flush_addr[0]};
`else
    assign raw_cmp   = 1'b0;
    assign raw_instr = w0.data;
    assign raw_valid = (count != '0);
    assign raw_pc    = w0.addr;
    assign pop       = consume;
    assign unused_ok = &{1'b0, flush_addr[1:0], w1};
`endif

    assign instr_valid = raw_valid;
    assign instr       = raw_valid ? raw_instr : '0;
    assign instr_pc    = raw_valid ? raw_pc : '0;
    assign compressed  = raw_valid && raw_cmp;

endmodule

// File: tb/tb_ifu_align.sv
// Self-checking bench for ifu_align.
// Applies a table of directed vectors and a randomized phase.
// Every cycle is also checked against a halfword-stream reference model.
module tb_ifu_align;

`ifdef IFU_ALIGN_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_addr = '0;
    logic [31:0] fetch_data = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        compressed;

    ifu_align #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .compressed  (compressed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // The model buffers a stream of halfwords with their addresses.
    // m_off indexes the halfword where the next instruction starts.
    logic [15:0] hq_dat[$];
    logic [31:0] hq_pc[$];
    int          m_off = 0;
    logic [31:0] m_exp = 32'h0;
    bit          e_v, e_c, e_rdy;
    logic [31:0] e_ins, e_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hq_dat.delete();
        hq_pc.delete();
        m_off = 0;
        m_exp = 32'h0;
    endtask

    task automatic model_eval();
        logic [15:0] h;
        e_v = 0; e_c = 0; e_ins = '0; e_pc = '0;
        e_rdy = (hq_dat.size() / 2) < DEPTH;
        if (hq_dat.size() > m_off) begin
            h = hq_dat[m_off];
            if (RVC && h[1:0] != 2'b11) begin
                e_v = 1; e_c = 1; e_ins = {16'h0, h}; e_pc = hq_pc[m_off];
            end else if (hq_dat.size() >= m_off + 2) begin
                e_v = 1; e_ins = {hq_dat[m_off+1], h}; e_pc = hq_pc[m_off];
            end
        end
    endtask

    // Uses e_* from model_eval of the pre-edge state.
    task automatic model_update(input bit fv, input logic [31:0] fa, input logic [31:0] fd,
                                input bit fl, input logic [31:0] fla, input bit ir);
        if (fl) begin
            hq_dat.delete();
            hq_pc.delete();
            m_off = RVC ? int'(fla[1]) : 0;
            m_exp = {fla[31:2], 2'b00};
        end else if (e_v && ir) begin
            m_off += e_c ? 1 : 2;
            while (m_off >= 2) begin
                void'(hq_dat.pop_front()); void'(hq_dat.pop_front());
                void'(hq_pc.pop_front());  void'(hq_pc.pop_front());
                m_off -= 2;
            end
        end
        if (fv && e_rdy && fa == m_exp) begin
            hq_dat.push_back(fd[15:0]);  hq_pc.push_back(fa);
            hq_dat.push_back(fd[31:16]); hq_pc.push_back(fa + 32'd2);
            m_exp = fa + 32'd4;
        end
    endtask

    // Entered and left at a negedge. Compares outputs against the model, then drives one clock edge.
    task automatic cycle(input bit fv, input logic [31:0] fa, input logic [31:0] fd,
                         input bit fl, input logic [31:0] fla, input bit ir);
        model_eval();
        check("m_valid", instr_valid, e_v);
        check("m_instr", instr, e_ins);
        check("m_pc", instr_pc, e_pc);
        check("m_cmp", compressed, e_c);
        check("m_frdy", fetch_ready, e_rdy);
        fetch_valid = fv; fetch_addr = fa; fetch_data = fd;
        flush = fl; flush_addr = fla; instr_ready = ir;
        @(posedge clk);
        model_update(fv, fa, fd, fl, fla, ir);
        @(negedge clk);
    endtask

    typedef struct {
        bit          fv;
        logic [31:0] fa, fd;
        bit          fl;
        logic [31:0] fla;
        bit          ir;
        bit          ev;
        logic [31:0] ei, ep;
        bit          ec, er;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit fv, input logic [31:0] fa, input logic [31:0] fd, input bit fl,
                       input logic [31:0] fla, input bit ir, input bit ev, input logic [31:0] ei,
                       input logic [31:0] ep, input bit ec, input bit er);
        vec_t v;
        v.fv = fv; v.fa = fa; v.fd = fd; v.fl = fl; v.fla = fla; v.ir = ir;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.er = er;
        tbl.push_back(v);
    endtask

    initial begin
        // Columns: fv fa fd fl fla ir | expected valid instr pc cmp fetch_ready (before the edge).
`ifdef IFU_ALIGN_RVC_EN
        add(0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 1);
        add(1, 0, 32'h00A00093, 0, 0, 1,            0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h00A00093, 0, 0, 1);
        add(1, 0, 32'h45054501, 1, 0, 1,            0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h4501, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h4505, 2, 1, 1);
        add(1, 0, 32'h00934501, 1, 0, 1,            0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h4501, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1,                       0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       0, 0, 0, 0, 1);
        add(1, 4, 32'h123400A0, 0, 0, 1,            0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h00A00093, 2, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h1234, 6, 1, 1);
        add(1, 8, 32'hDEADBEEF, 1, 32'h102, 1,      0, 0, 0, 0, 1);
        add(1, 32'h100, 32'h4501ABCD, 0, 0, 1,      0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h4501, 32'h102, 1, 1);
        add(1, 32'h104, 32'hAAAA0013, 0, 0, 0,      0, 0, 0, 0, 1);
        add(1, 32'h108, 32'hBBBB0013, 0, 0, 0,      1, 32'hAAAA0013, 32'h104, 0, 1);
        add(1, 32'h10C, 32'hCCCC0013, 0, 0, 0,      1, 32'hAAAA0013, 32'h104, 0, 1);
        add(1, 32'h110, 32'hDDDD0013, 0, 0, 0,      1, 32'hAAAA0013, 32'h104, 0, 1);
        add(1, 32'h114, 32'hEEEE0013, 0, 0, 0,      1, 32'hAAAA0013, 32'h104, 0, 0);
        add(1, 32'h114, 32'hEEEE0013, 0, 0, 0,      1, 32'hAAAA0013, 32'h104, 0, 0);
        add(0, 0, 0, 0, 0, 1,                       1, 32'hAAAA0013, 32'h104, 0, 0);
        add(1, 32'h114, 32'h45010000, 1, 32'h116, 1, 1, 32'hBBBB0013, 32'h108, 0, 1);
        add(0, 0, 0, 0, 0, 0,                       1, 32'h4501, 32'h116, 1, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h4501, 32'h116, 1, 1);
        add(0, 0, 0, 0, 0, 1,                       0, 0, 0, 0, 1);
`else
        add(0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 1);
        add(1, 0, 32'h00A00093, 0, 0, 1,            0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h00A00093, 0, 0, 1);
        add(1, 32'h100, 32'h4501ABCD, 1, 32'h102, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,                       1, 32'h4501ABCD, 32'h100, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h4501ABCD, 32'h100, 0, 1);
        add(1, 32'h104, 32'h12345678, 0, 0, 1,      0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       1, 32'h12345678, 32'h104, 0, 1);
        add(0, 0, 0, 0, 0, 1,                       0, 0, 0, 0, 1);
`endif

        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            check($sformatf("t%0d_valid", i), instr_valid, tbl[i].ev);
            check($sformatf("t%0d_instr", i), instr, tbl[i].ei);
            check($sformatf("t%0d_pc", i), instr_pc, tbl[i].ep);
            check($sformatf("t%0d_cmp", i), compressed, tbl[i].ec);
            check($sformatf("t%0d_frdy", i), fetch_ready, tbl[i].er);
            cycle(tbl[i].fv, tbl[i].fa, tbl[i].fd, tbl[i].fl, tbl[i].fla, tbl[i].ir);
        end

        // Randomized traffic: mostly in-order words, with some stale words, redirects and stalls.
        for (int n = 0; n < 4000; n++) begin
            bit          fv, fl, ir;
            int          r;
            logic [31:0] fla, base, fa;
            fl   = ($urandom_range(0, 24) == 0);
            fla  = $urandom & 32'h0000_0FFE;
            base = fl ? {fla[31:2], 2'b00} : m_exp;
            r    = $urandom_range(0, 9);
            fa   = (r < 7) ? base : ((r < 9) ? base + 32'd4 : m_exp - 32'd4);
            fv   = ($urandom_range(0, 99) < 70);
            ir   = ($urandom_range(0, 99) < (((n / 500) % 2 == 0) ? 80 : 30));
            cycle(fv, fa, $urandom, fl, fla, ir);
        end

        // Asynchronous reset while the buffer is busy.
        cycle(1, m_exp, 32'h00000013, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", instr_valid, 0);
        check("rst_frdy", fetch_ready, 1);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_cmp", compressed, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 32'h0, 32'h00A00093, 0, 0, 0);
        check("post_rst_valid", instr_valid, 1);
        check("post_rst_instr", instr, 32'h00A00093);
        check("post_rst_pc", instr_pc, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
